// File: rtl/hamming_decoder.sv
// Hamming(12,8) single-error-correcting decoder, two-stage valid/ready pipeline,
// with saturating counters of corrected and uncorrectable words delivered.
module hamming_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [11:0]      in_cw,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [3:0]       out_syn,
    output logic             out_corr,
    output logic             out_uncorr,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);
    localparam int STAGES = 2;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] syn;
        logic       corr;
        logic       uncorr;
    } rsp_t;

    logic [STAGES:1] vld_pipe;
    logic [11:0]     s1_cw;
    logic [3:0]      s1_syn;
    logic [3:0]      in_syn;
    logic [11:0]     fixed_cw;
    rsp_t            dec;
    rsp_t            s2_rsp;
    logic            s1_load;
    logic            s2_load;
    logic            out_xfer;

    function automatic logic [7:0] extract(input logic [11:0] cw);
        return {cw[11], cw[10], cw[9], cw[8], cw[6], cw[5], cw[4], cw[2]};
    endfunction

    // Bit i of the codeword is code position i+1.
    always_comb begin
        in_syn = '0;
        for (int i = 0; i < 12; i++) begin
            for (int k = 0; k < 4; k++) begin
                if (((i + 1) >> k) % 2 == 1)
                    in_syn[k] = in_syn[k] ^ in_cw[i];
            end
        end
    end

    assign s2_load  = !vld_pipe[2] || out_ready;
    assign s1_load  = !vld_pipe[1] || s2_load;
    assign in_ready = !rst && s1_load;
    assign out_xfer = vld_pipe[2] && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe[1] <= 1'b0;
            s1_cw       <= '0;
            s1_syn      <= '0;
        end else if (s1_load) begin
            vld_pipe[1] <= in_valid;
            s1_cw       <= in_cw;
            s1_syn      <= in_syn;
        end
    end

    // Syndromes 13..15 point past the word, so the raw data is passed through.
    always_comb begin
        fixed_cw = s1_cw;
        for (int i = 0; i < 12; i++) begin
            if (s1_syn == 4'(i + 1))
                fixed_cw[i] = ~s1_cw[i];
        end
        dec.data   = extract(fixed_cw);
        dec.syn    = s1_syn;
        dec.corr   = (s1_syn != 4'd0) && (s1_syn <= 4'd12);
        dec.uncorr = (s1_syn > 4'd12);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe[2] <= 1'b0;
            s2_rsp      <= '0;
        end else if (s2_load) begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1])
                s2_rsp <= dec;
        end
    end

    assign out_valid  = vld_pipe[2];
    assign out_data   = s2_rsp.data;
    assign out_syn    = s2_rsp.syn;
    assign out_corr   = s2_rsp.corr;
    assign out_uncorr = s2_rsp.uncorr;

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (out_xfer) begin
            if (s2_rsp.corr && corr_cnt != '1)
                corr_cnt <= corr_cnt + CNT_W'(1);
            if (s2_rsp.uncorr && uncorr_cnt != '1)
                uncorr_cnt <= uncorr_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hamming_decoder.sv
// Directed bench for hamming_decoder: vector table, backpressure stream, reset mid-flight.
module tb_hamming_decoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [11:0] in_cw = '0;
    logic        out_ready = 1'b1;
    logic        cnt_clr = 1'b0;
    logic        in_ready, out_valid, out_corr, out_uncorr;
    logic [7:0]  out_data;
    logic [3:0]  out_syn;
    logic [15:0] corr_cnt, uncorr_cnt;
    logic        in_ready2, out_valid2, out_corr2, out_uncorr2;
    logic [7:0]  out_data2;
    logic [3:0]  out_syn2;
    logic [1:0]  corr_cnt2, uncorr_cnt2;

    always #5 clk = ~clk;

    hamming_decoder #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_cw(in_cw),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_syn(out_syn),
        .out_corr(out_corr), .out_uncorr(out_uncorr), .cnt_clr(cnt_clr),
        .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt));

    hamming_decoder #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_cw(in_cw),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_syn(out_syn2),
        .out_corr(out_corr2), .out_uncorr(out_uncorr2), .cnt_clr(cnt_clr),
        .corr_cnt(corr_cnt2), .uncorr_cnt(uncorr_cnt2));

    typedef struct {
        logic [11:0] cw;
        logic        clr;
        logic [7:0]  data;
        logic [3:0]  syn;
        logic        corr;
        logic        uncorr;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    int ec16 = 0, eu16 = 0, ec2 = 0, eu2 = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    task automatic chk_cnt(input string nm);
        chk({nm, "_corr16"}, 32'(corr_cnt), 32'(ec16));
        chk({nm, "_uncorr16"}, 32'(uncorr_cnt), 32'(eu16));
        chk({nm, "_corr2"}, 32'(corr_cnt2), 32'(ec2));
        chk({nm, "_uncorr2"}, 32'(uncorr_cnt2), 32'(eu2));
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        in_valid = 1'b1;
        in_cw    = v.cw;
        #1 chk("vec_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("vec_early_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("vec_out_valid", 32'(out_valid), 32'd1);
        chk("vec_data", 32'(out_data), 32'(v.data));
        chk("vec_syn", 32'(out_syn), 32'(v.syn));
        chk("vec_corr", 32'(out_corr), 32'(v.corr));
        chk("vec_uncorr", 32'(out_uncorr), 32'(v.uncorr));
        chk("vec_data2", 32'(out_data2), 32'(v.data));
        chk_cnt("vec_pre");
        cnt_clr = v.clr;
        @(negedge clk);
        cnt_clr = 1'b0;
        if (v.clr) begin
            ec16 = 0; eu16 = 0; ec2 = 0; eu2 = 0;
        end else begin
            if (v.corr)   begin ec16 = sat(ec16, 65535); ec2 = sat(ec2, 3); end
            if (v.uncorr) begin eu16 = sat(eu16, 65535); eu2 = sat(eu2, 3); end
        end
        chk("vec_drained", 32'(out_valid), 32'd0);
        chk_cnt("vec_post");
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{12'hF77, 1'b0, 8'hFF, 4'd0,  1'b0, 1'b0};
        vecs[1]  = '{12'hF57, 1'b0, 8'hFF, 4'd6,  1'b1, 1'b0};
        vecs[2]  = '{12'h776, 1'b0, 8'h7F, 4'd13, 1'b0, 1'b1};
        vecs[3]  = '{12'hF74, 1'b0, 8'hFE, 4'd3,  1'b1, 1'b0};
        vecs[4]  = '{12'hF76, 1'b0, 8'hFF, 4'd1,  1'b1, 1'b0};
        vecs[5]  = '{12'h000, 1'b0, 8'h00, 4'd0,  1'b0, 1'b0};
        vecs[6]  = '{12'h777, 1'b0, 8'hFF, 4'd12, 1'b1, 1'b0};
        vecs[7]  = '{12'h007, 1'b0, 8'h01, 4'd0,  1'b0, 1'b0};
        vecs[8]  = '{12'h017, 1'b0, 8'h01, 4'd5,  1'b1, 1'b0};
        vecs[9]  = '{12'h804, 1'b0, 8'h81, 4'd15, 1'b0, 1'b1};
        vecs[10] = '{12'h802, 1'b0, 8'h80, 4'd14, 1'b0, 1'b1};
        vecs[11] = '{12'hF57, 1'b1, 8'hFF, 4'd6,  1'b1, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_fields", {out_data, out_syn, out_corr, out_uncorr}, 32'd0);
        chk_cnt("rst");
        rst = 1'b0;
        #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure: 8 single-error words (positions 1..8), 5-cycle output stall
        begin
            int sent = 0, rcvd = 0;
            logic stalled = 1'b0, saw_block = 1'b0;
            logic [7:0] h_data = '0;
            logic [3:0] h_syn = '0;
            for (int cyc = 0; cyc < 60 && rcvd < 8; cyc++) begin
                @(negedge clk);
                out_ready = !(cyc >= 3 && cyc < 8);
                in_valid  = (sent < 8);
                in_cw     = 12'hF77 ^ (12'h001 << sent);
                #1;
                if (stalled) begin
                    chk("bp_hold_valid", 32'(out_valid), 32'd1);
                    chk("bp_hold_data", 32'(out_data), 32'(h_data));
                    chk("bp_hold_syn", 32'(out_syn), 32'(h_syn));
                end
                if (in_valid && !in_ready) saw_block = 1'b1;
                if (out_valid && out_ready) begin
                    chk("bp_order_syn", 32'(out_syn), 32'(rcvd + 1));
                    chk("bp_data", 32'(out_data), 32'hFF);
                    chk("bp_corr", 32'(out_corr), 32'd1);
                    rcvd++;
                end
                stalled = out_valid && !out_ready;
                h_data  = out_data;
                h_syn   = out_syn;
                if (in_valid && in_ready) sent++;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            chk("bp_received", 32'(rcvd), 32'd8);
            chk("bp_in_ready_dropped", 32'(saw_block), 32'd1);
            repeat (8) begin ec16 = sat(ec16, 65535); ec2 = sat(ec2, 3); end
            @(negedge clk);
            chk("bp_no_dup", 32'(out_valid), 32'd0);
            chk_cnt("bp");
        end

        // Reset with two words in flight
        @(negedge clk);
        in_valid = 1'b1;
        in_cw    = 12'hF57;
        @(negedge clk);
        in_cw    = 12'h776;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_valid_before_rst", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        ec16 = 0; eu16 = 0; ec2 = 0; eu2 = 0;
        chk_cnt("mid_rst");
        rst = 1'b0;
        #1 chk("mid_post_rst_in_ready", 32'(in_ready), 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("mid_no_stale", 32'(out_valid), 32'd0);
        end
        chk_cnt("mid_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
